// File: rtl/mem_bus_out_port_if.sv
// CPU-side control and downstream stream signals of the memory-mapped output port.
// The shared data bus stays a plain inout on the module.
interface mem_bus_out_port_if;
  logic        CS;
  logic        WE;
  logic [6:0]  ADDR;
  logic        HIT;
  logic [31:0] OUT_DATA;
  logic        OUT_VALID;
  logic        OUT_READY;

  modport slave (
    input  CS, WE, ADDR, OUT_READY,
    output HIT, OUT_DATA, OUT_VALID
  );

  modport master (
    output CS, WE, ADDR, OUT_READY,
    input  HIT, OUT_DATA, OUT_VALID
  );
endinterface

// File: rtl/mem_bus_out_port.sv
// Memory-mapped output port: CPU writes to DATA queue words into a FIFO drained by a
// valid/ready sink; STATUS reports fill level, overflow, full and empty.
module mem_bus_out_port #(
  parameter int         DEPTH     = 8,
  parameter logic [6:0] DATA_ADDR = 7'h7E,
  parameter logic [6:0] STAT_ADDR = 7'h7F
) (
  input  logic                CLK,
  input  logic                RST,
  mem_bus_out_port_if.slave   bus,
  inout  wire  [31:0]         Mem_Bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;

  // Negedge (bus-side) registers
  logic          wr_pend_q, clr_pend_q;
  logic [31:0]   pend_data_q, rd_data_q;

  logic data_hit, stat_hit, bus_wr, bus_rd;
  logic full, empty, pop, push_ok, overflow;
  logic [31:0] status;

  assign data_hit = (bus.ADDR == DATA_ADDR);
  assign stat_hit = (bus.ADDR == STAT_ADDR);
  assign bus.HIT  = data_hit | stat_hit;
  assign bus_wr   = bus.CS &  bus.WE;
  assign bus_rd   = bus.CS & ~bus.WE & bus.HIT;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign status = {20'b0, 5'(count_q), 4'b0, ovf_q, full, empty};

  assign Mem_Bus = bus_rd ? rd_data_q : 'z;

  // Bus accesses are sampled on the falling edge, like the companion memory. The
  // pending flags are recomputed every negedge, so each sampled write is seen by
  // exactly one following posedge without the posedge side having to clear them.
  always_ff @(negedge CLK or negedge RST) begin
    if (!RST) begin
      wr_pend_q   <= 1'b0;
      clr_pend_q  <= 1'b0;
      pend_data_q <= '0;
      rd_data_q   <= '0;
    end else begin
      wr_pend_q  <= bus_wr & data_hit;
      clr_pend_q <= bus_wr & stat_hit;
      if (bus_wr && data_hit) pend_data_q <= Mem_Bus;
      if (bus_rd)             rd_data_q   <= stat_hit ? status : 32'h0;
    end
  end

  // A pop in the same edge frees the slot, so a push into a full FIFO still lands.
  assign pop      = ~empty & bus.OUT_READY;
  assign push_ok  = wr_pend_q & (~full | pop);
  assign overflow = wr_pend_q & full & ~pop;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (clr_pend_q)    ovf_d = 1'b0;
    else if (overflow) ovf_d = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  // NOTE: storage is deliberately not reset; empty gates OUT_DATA, so stale words never leak.
  always_ff @(posedge CLK) begin
    if (push_ok) mem_q[wr_ptr_q] <= pend_data_q;
  end

  assign bus.OUT_VALID = ~empty;
  assign bus.OUT_DATA  = empty ? 32'h0 : mem_q[rd_ptr_q];

endmodule

// File: tb/tb_mem_bus_out_port.sv
// Directed bench for mem_bus_out_port: bus writes/reads, overflow, simultaneous
// push/pop when full, address decode, and mid-stream reset.
module tb_mem_bus_out_port;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        bus_oe = 1'b0;
  logic [31:0] bus_drv = '0;
  wire  [31:0] mem_bus;

  int n_checks = 0;
  int n_errors = 0;

  mem_bus_out_port_if bus_if ();

  assign mem_bus = bus_oe ? bus_drv : 'z;

  mem_bus_out_port dut (
    .CLK     (clk),
    .RST     (rst_n),
    .bus     (bus_if),
    .Mem_Bus (mem_bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Called at posedge+1; returns at the following posedge+1 with the bus idle.
  task automatic bus_write(input logic [6:0] addr, input logic [31:0] data, input logic cs);
    bus_if.CS   = cs;
    bus_if.WE   = 1'b1;
    bus_if.ADDR = addr;
    bus_drv     = data;
    bus_oe      = 1'b1;
    @(posedge clk); #1;
    bus_if.CS = 1'b0;
    bus_if.WE = 1'b0;
    bus_oe    = 1'b0;
  endtask

  task automatic bus_read(input logic [6:0] addr, output logic [31:0] data, output logic hit);
    bus_if.CS   = 1'b1;
    bus_if.WE   = 1'b0;
    bus_if.ADDR = addr;
    @(negedge clk); #1;
    data = mem_bus;
    hit  = bus_if.HIT;
    @(posedge clk); #1;
    bus_if.CS = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  logic [31:0] rd;
  logic        hit;
  logic        bus_idle;
  logic [31:0] drain_exp [8] = '{32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd10};

  initial begin
    bus_if.CS = 1'b0;
    bus_if.WE = 1'b0;
    bus_if.ADDR = 7'h00;
    bus_if.OUT_READY = 1'b0;

    // Reset state
    #12;
    check("rst_valid", {31'b0, bus_if.OUT_VALID}, 32'h0);
    check("rst_data", bus_if.OUT_DATA, 32'h0);
    check("rst_hit_addr0", {31'b0, bus_if.HIT}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);
    bus_read(7'h7F, rd, hit);
    check("stat_after_rst", rd, 32'h0000_0001);

    // Single write, no sink
    bus_write(7'h7E, 32'hDEADBEEF, 1'b1);
    check("single_valid", {31'b0, bus_if.OUT_VALID}, 32'h1);
    check("single_data", bus_if.OUT_DATA, 32'hDEADBEEF);
    bus_read(7'h7F, rd, hit);
    check("single_stat", rd, 32'h0000_0080);
    bus_read(7'h7E, rd, hit);
    check("data_read_zero", rd, 32'h0);
    bus_read(7'h7F, rd, hit);
    check("data_read_no_effect", rd, 32'h0000_0080);
    bus_if.OUT_READY = 1'b1;
    idle(1);
    bus_if.OUT_READY = 1'b0;
    check("single_drained", {31'b0, bus_if.OUT_VALID}, 32'h0);

    // Nine writes into an eight-deep FIFO
    for (int i = 1; i <= 9; i++) bus_write(7'h7E, 32'(i), 1'b1);
    bus_read(7'h7F, rd, hit);
    check("overflow_stat", rd, 32'h0000_0406);
    bus_write(7'h7F, 32'hFFFF_FFFF, 1'b1);
    bus_read(7'h7F, rd, hit);
    check("ovf_cleared_stat", rd, 32'h0000_0402);
    idle(2);
    check("stable_head", bus_if.OUT_DATA, 32'd1);

    // Full FIFO: pop and push on the same edge
    bus_if.OUT_READY = 1'b1;
    bus_write(7'h7E, 32'd10, 1'b1);
    bus_if.OUT_READY = 1'b0;
    bus_read(7'h7F, rd, hit);
    check("full_pushpop_stat", rd, 32'h0000_0402);
    bus_if.OUT_READY = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain_valid_%0d", i), {31'b0, bus_if.OUT_VALID}, 32'h1);
      check($sformatf("drain_data_%0d", i), bus_if.OUT_DATA, drain_exp[i]);
      @(posedge clk); #1;
    end
    bus_if.OUT_READY = 1'b0;
    check("drain_empty", {31'b0, bus_if.OUT_VALID}, 32'h0);

    // Decode: other address and deselected writes change nothing
    bus_write(7'h10, 32'h77, 1'b1);
    bus_write(7'h7E, 32'h88, 1'b0);
    check("nohit_valid", {31'b0, bus_if.OUT_VALID}, 32'h0);
    bus_read(7'h7F, rd, hit);
    check("stat_hit", {31'b0, hit}, 32'h1);
    check("stat_driven", rd, 32'h0000_0001);
    bus_read(7'h10, rd, hit);
    bus_idle = $isunknown(rd) ? 1'b1 : (rd == 32'h0);
    check("other_hit", {31'b0, hit}, 32'h0);
    check("other_bus_z", {31'b0, bus_idle}, 32'h1);

    // Mid-stream reset with a write already latched
    for (int i = 0; i < 3; i++) bus_write(7'h7E, 32'hA0 + 32'(i), 1'b1);
    bus_read(7'h7F, rd, hit);
    check("three_queued", rd, 32'h0000_0180);
    bus_if.CS = 1'b1;
    bus_if.WE = 1'b1;
    bus_if.ADDR = 7'h7E;
    bus_drv = 32'h55;
    bus_oe = 1'b1;
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", {31'b0, bus_if.OUT_VALID}, 32'h0);
    check("midrst_data", bus_if.OUT_DATA, 32'h0);
    bus_if.CS = 1'b0;
    bus_if.WE = 1'b0;
    bus_oe = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(2);
    check("lost_write_valid", {31'b0, bus_if.OUT_VALID}, 32'h0);
    bus_read(7'h7F, rd, hit);
    check("stat_after_midrst", rd, 32'h0000_0001);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
